// File: rtl/data_mem_pkg.sv
// Shared encodings and lane helpers for the byte-addressed MEM-stage data memory.
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE    = 1'b0,
    IO_WAIT = 1'b1
  } state_t;

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~off[0];
      SIZE_WORD: ok = (off == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ld_extend.sv
// Load lane select and sign/zero extension, shared by the RAM and IO read paths.
module ld_extend
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {off, 3'b000};
    case (size)
      SIZE_BYTE: result = unsigned_ld ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: result = unsigned_ld ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_v4.sv
// Byte-addressed data memory with registered loads, alignment checks and an
// IO window forwarded over a req/ack handshake with timeout.
module data_mem_v4
  import data_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 256,
  parameter int IO_BASE    = 1024,
  parameter int IO_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wtData,
  output logic [31:0]       rdData,
  output logic              rd_valid,
  output logic              misalign,
  output logic              bus_err,
  output logic              stall,
  output logic              io_req,
  output logic              io_we,
  output logic [ADDR_W-1:0] io_addr,
  output logic [31:0]       io_wdata,
  output logic [3:0]        io_be,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(IO_TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic [31:0]       rd_data_reg, rd_data_next;
  logic              rd_valid_reg, rd_valid_next;
  logic              misalign_reg, misalign_next;
  logic              bus_err_reg, bus_err_next;
  logic              io_req_reg, io_req_next;
  logic              io_we_reg, io_we_next;
  logic [ADDR_W-1:0] io_addr_reg, io_addr_next;
  logic [31:0]       io_wdata_reg, io_wdata_next;
  logic [3:0]        io_be_reg, io_be_next;
  logic [1:0]        io_size_reg, io_size_next;
  logic              io_uns_reg, io_uns_next;

  logic              accept, ok, is_io, ram_wr;
  logic [3:0]        be;
  logic [31:0]       wdata_rep, ram_word, ram_ext, io_ext;
  logic [IDX_W-1:0]  idx;

  assign accept = ce && (state_reg == IDLE);
  assign ok     = aligned(size, addr[1:0]);
  assign be     = be_of(size, addr[1:0]);
  assign is_io  = (addr >= ADDR_W'(IO_BASE));
  assign ram_wr = accept && ok && !is_io && we && !rst;
  assign idx    = addr[IDX_W+1:2];
  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_comb begin
    case (size)
      SIZE_BYTE: wdata_rep = {4{wtData[7:0]}};
      SIZE_HALF: wdata_rep = {2{wtData[15:0]}};
      default:   wdata_rep = wtData;
    endcase
  end

  // One narrow RAM per byte lane so each enable maps to its own write port.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (ram_wr && be[gi])
        lane_mem[idx] <= wdata_rep[8*gi +: 8];
    end
    assign ram_word[8*gi +: 8] = lane_mem[idx];
  end

  ld_extend u_ram_ext (
    .word(ram_word), .off(addr[1:0]), .size(size),
    .unsigned_ld(unsigned_ld), .result(ram_ext)
  );

  ld_extend u_io_ext (
    .word(io_rdata), .off(io_addr_reg[1:0]), .size(io_size_reg),
    .unsigned_ld(io_uns_reg), .result(io_ext)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rd_data_next  = rd_data_reg;
    rd_valid_next = 1'b0;
    misalign_next = 1'b0;
    bus_err_next  = 1'b0;
    io_req_next   = io_req_reg;
    io_we_next    = io_we_reg;
    io_addr_next  = io_addr_reg;
    io_wdata_next = io_wdata_reg;
    io_be_next    = io_be_reg;
    io_size_next  = io_size_reg;
    io_uns_next   = io_uns_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!ok) begin
            misalign_next = 1'b1;
          end else if (is_io) begin
            state_next    = IO_WAIT;
            cnt_next      = '0;
            io_req_next   = 1'b1;
            io_we_next    = we;
            io_addr_next  = addr;
            io_wdata_next = wdata_rep;
            io_be_next    = be;
            io_size_next  = size;
            io_uns_next   = unsigned_ld;
          end else if (!we) begin
            rd_data_next  = ram_ext;
            rd_valid_next = 1'b1;
          end
        end
      end
      IO_WAIT: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (io_ack) begin
          state_next  = IDLE;
          io_req_next = 1'b0;
          if (!io_we_reg) begin
            rd_data_next  = io_ext;
            rd_valid_next = 1'b1;
          end
        end else if (cnt_inc == CNT_W'(IO_TIMEOUT)) begin
          state_next   = IDLE;
          cnt_next     = '0;
          io_req_next  = 1'b0;
          bus_err_next = 1'b1;
          if (!io_we_reg)
            rd_data_next = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      misalign_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
      io_req_reg   <= 1'b0;
      io_we_reg    <= 1'b0;
      io_addr_reg  <= '0;
      io_wdata_reg <= '0;
      io_be_reg    <= '0;
      io_size_reg  <= '0;
      io_uns_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
      misalign_reg <= misalign_next;
      bus_err_reg  <= bus_err_next;
      io_req_reg   <= io_req_next;
      io_we_reg    <= io_we_next;
      io_addr_reg  <= io_addr_next;
      io_wdata_reg <= io_wdata_next;
      io_be_reg    <= io_be_next;
      io_size_reg  <= io_size_next;
      io_uns_reg   <= io_uns_next;
    end
  end

  assign rdData   = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign misalign = misalign_reg;
  assign bus_err  = bus_err_reg;
  assign stall    = (state_reg == IO_WAIT);
  assign io_req   = io_req_reg;
  assign io_we    = io_we_reg;
  assign io_addr  = io_addr_reg;
  assign io_wdata = io_wdata_reg;
  assign io_be    = io_be_reg;

endmodule

// File: doc/data_mem_v4.md
Name: data_mem_v4

Overview:
- Parametrised next-generation data memory for the MIPS CPU MEM stage.
- Replaces the word-only, combinational-read RAM with:
  - byte-addressed storage with byte/half/word stores using lane enables;
  - sign- or zero-extended sub-word loads;
  - registered reads with a valid strobe;
  - alignment checking;
  - an IO-mapped window forwarded over a req/ack handshake with timeout.
- Drives a pipeline stall while an IO access is outstanding.

Parameters:
- ADDR_W, 32, byte-address width.
- DEPTH, 256, RAM depth in 32-bit words; power of two.
- IO_BASE, 1024, first byte address of the IO window. Must be at least DEPTH*4.
- IO_TIMEOUT, 15, maximum cycles to wait for io_ack before aborting; must be at least 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  access request.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- unsigned_ld  input  1  1 = zero-extend sub-word load, 0 = sign-extend.
- addr  input  ADDR_W  byte address.
- wtData  input  32  store data, right-justified.
- rdData  output  32  load result.
- rd_valid  output  1  one-cycle pulse: rdData is valid.
- misalign  output  1  one-cycle pulse: access rejected (alignment or illegal size).
- bus_err  output  1  one-cycle pulse: IO access timed out.
- stall  output  1  upstream must hold ce, we, size, addr and wtData.
- io_req  output  1  IO access pending.
- io_we  output  1  IO store.
- io_addr  output  ADDR_W  IO byte address.
- io_wdata  output  32  lane-positioned IO store data.
- io_be  output  4  IO byte enables.
- io_rdata  input  32  IO read word (full word, unextended).
- io_ack  input  1  IO completion, single-cycle pulse.

Behaviour:
- Reset: rdData=0, rd_valid=0, misalign=0, bus_err=0, stall=0, io_req=0, io_we=0, io_addr=0, io_wdata=0, io_be=0; FSM=IDLE; timeout counter=0. RAM contents are not reset (X until written).
- Reset mid-IO: io_req drops the next cycle and the pending access is discarded with no response.
- Accept: an access is accepted on a rising edge with ce=1 and stall=0.
- Lanes: little-endian, off=addr[1:0], byte lane k = bits [8k+7:8k].
  - byte: be = 1<<off.
  - half: be = 0011 or 1100.
  - word: be = 1111.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=0; size=11 always fails.
  - A failing access performs no RAM write and no IO access.
  - Next cycle: misalign=1, rd_valid=0, rdData unchanged.
- RAM region (addr < IO_BASE):
  - Word index = addr[log2(DEPTH)+1:2]; the upper bits alias.
  - Store: enabled lanes are written on the accept edge. Store data is replicated: byte = wtData[7:0]×4, half = wtData[15:0]×2. No response pulse.
  - Load: 1-cycle latency. The lane is selected and extended, then registered into rdData, with rd_valid=1 in the cycle after accept.
  - A load on the cycle after a store to the same word returns the new data.
- IO region (addr >= IO_BASE), FSM IDLE/IO_WAIT:
  - IDLE→IO_WAIT on accept. io_req, io_we, io_addr, io_be and io_wdata are registered and held stable; stall=1 throughout IO_WAIT; the counter starts at 0.
  - IO_WAIT→IDLE on io_ack=1:
    - load: io_rdata is lane-selected and extended into rdData; rd_valid=1 the next cycle;
    - store: no pulse.
    - io_req and stall drop the next cycle.
  - The counter increments each IO_WAIT cycle without ack. If it reaches IO_TIMEOUT: →IDLE, bus_err=1 for one cycle, rdData=0 on a load, rd_valid=0.
  - An io_ack on the timeout cycle wins; no bus_err is raised.
  - An io_ack in IDLE is ignored.
- Back-to-back RAM accesses: one per cycle, no bubbles. stall is purely a function of FSM state and is registered.
- rd_valid, misalign and bus_err are mutually exclusive in any cycle.

Decomposition:
- Package data_mem_pkg:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings;
  - state encoding IDLE/IO_WAIT;
  - function be_of(size, off);
  - function aligned(size, off).
- One sub-module, ld_extend: combinational lane select plus sign/zero extension (inputs word, off, size, unsigned_ld). Shared by the RAM and IO load paths.

Test Plan:
- Word store then load: sw 0x12345678 to 0x10, then lw 0x10 → rd_valid the cycle after accept, rdData=0x12345678.
- Byte store plus extension: sb 0xAB to 0x13, then lb 0x13 → 0xFFFFFFAB; lbu 0x13 → 0x000000AB. lw 0x10 → 0xAB345678.
- Alignment errors:
  - lh 0x11 → misalign pulse, no rd_valid.
  - sw 0x12 → misalign, and a subsequent lw 0x10 is unchanged.
  - size=11 → misalign.
- IO load with 3-cycle latency: lh at IO_BASE+2, io_rdata=0x8001_0000, ack on the 3rd IO_WAIT cycle.
  - io_be=1100 and stall held while waiting.
  - Then rd_valid with rdData=0xFFFF8001, and stall low the following cycle.
- IO timeout: IO load with ack never asserted → bus_err after IO_TIMEOUT cycles, rdData=0, FSM returns to IDLE and the next RAM load proceeds normally.
- Reset during IO_WAIT: assert rst mid-wait → the next cycle has io_req=0, stall=0 and no response pulse. A late io_ack is ignored.
